note_sequencer: RTL and testbench

Melody playback stage of the music engine, directly upstream of the 3-to-8 note decoder. Holds a small writable melody table, steps through it at a fixed tick rate, and drives the 3-bit note select plus a note-on gate that the decoder expands into one-hot tone-generator enables. Rests, per-note durations, an end marker and optional looping are handled here, so downstream stages stay purely combinational.

---
 rtl/music_pkg.sv | 22 ++
 rtl/tick_timer.sv | 29 ++
 rtl/note_sequencer.sv | 126 ++++++++++++
 tb/tb_note_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types for the melody playback path: note index, packed melody entry,
// end marker and sequencer state encoding.
package music_pkg;

   typedef logic [2:0] note_t;

   typedef struct packed {
      logic       rest;
      note_t      note;
      logic [3:0] dur;
   } mel_entry_t;

   localparam logic [7:0] MEL_END = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_PLAY,
      S_ENDSEQ
   } seq_state_t;

endpackage

// File: rtl/tick_timer.sv
// Free-running duration tick: raises o_tick for one cycle every TICK_CYCLES
// cycles; i_clr restarts the period and masks the tick.
module tick_timer #(
   parameter int TICK_CYCLES = 3125000
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_clr,
   output logic o_tick
);

   localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= '0;
      end else if (i_clr || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Melody table playback feeding the 3-to-8 note decoder.
// Define NOTE_SEQ_LOOP_EN to make playback restart at entry 0 after each pass.
module note_sequencer
   import music_pkg::*;
#(
   parameter int TICK_CYCLES = 3125000,
   parameter int MEL_LEN     = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       load_we,
   input  logic [$clog2(MEL_LEN)-1:0] load_addr,
   input  logic [7:0]                 load_data,
   output logic [2:0]                 note_sel,
   output logic                       note_on,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(MEL_LEN)-1:0] step_idx
);

   localparam int IW = $clog2(MEL_LEN);

   seq_state_t    r_state;
   seq_state_t    w_next;
   mel_entry_t    r_table [MEL_LEN];
   logic [IW:0]   r_idx;
   logic [3:0]    r_dur;
   logic [3:0]    r_tcnt;
   note_t         r_note_sel;
   logic          r_note_on;
   logic [IW-1:0] r_step_idx;
   mel_entry_t    w_entry;
   logic          w_end;
   logic          w_tick;
   logic          w_last_tick;

   tick_timer #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .i_clr  (r_state != S_PLAY),
      .o_tick (w_tick)
   );

   // r_idx carries one extra bit so running off the end of a full table reads as END
   assign w_entry     = r_table[r_idx[IW-1:0]];
   assign w_end       = (w_entry == MEL_END) || r_idx[IW];
   assign w_last_tick = w_tick && (r_tcnt == r_dur);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (stop) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = w_end ? S_ENDSEQ : S_PLAY;
            S_PLAY:   if (w_last_tick) w_next = S_FETCH;
            S_ENDSEQ: begin
`ifdef NOTE_SEQ_LOOP_EN
               w_next = (r_idx != '0) ? S_FETCH : S_IDLE;
`else
               w_next = S_IDLE;
`endif
            end
            default:  w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < MEL_LEN; i++) r_table[i] <= '0;
      end else if (load_we && (r_state == S_IDLE)) begin
         r_table[load_addr] <= mel_entry_t'(load_data);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_idx      <= '0;
         r_dur      <= '0;
         r_tcnt     <= '0;
         r_note_sel <= '0;
         r_note_on  <= 1'b0;
         r_step_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_next == S_FETCH) r_idx <= '0;
            S_FETCH: begin
               if (w_next == S_PLAY) begin
                  r_dur      <= w_entry.dur;
                  r_tcnt     <= '0;
                  r_step_idx <= r_idx[IW-1:0];
                  r_note_on  <= !w_entry.rest;
                  // a rest keeps the previous note selected so the decoder input stays stable
                  if (!w_entry.rest) r_note_sel <= w_entry.note;
               end
            end
            S_PLAY: begin
               if (w_tick) r_tcnt <= r_tcnt + 4'd1;
               if (w_next == S_FETCH) r_idx <= r_idx + (IW+1)'(1);
            end
            S_ENDSEQ: r_idx <= '0;
            default: ;
         endcase
         if (w_next != S_PLAY) r_note_on <= 1'b0;
      end
   end

   assign note_sel = r_note_sel;
   assign note_on  = r_note_on;
   assign step_idx = r_step_idx;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_ENDSEQ);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with TICK_CYCLES=4: directed summary vectors, corner
// sequences and random melodies checked cycle by cycle against a playback model.
module tb_note_sequencer;

   localparam int TC = 4;
   localparam int ML = 32;
`ifdef NOTE_SEQ_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       load_we = 1'b0;
   logic [4:0] load_addr = '0;
   logic [7:0] load_data = '0;
   logic [2:0] note_sel;
   logic       note_on;
   logic       busy;
   logic       done;
   logic [4:0] step_idx;

   int n_cmp = 0;
   int n_bad = 0;

   note_sequencer #(.TICK_CYCLES(TC), .MEL_LEN(ML)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .stop      (stop),
      .load_we   (load_we),
      .load_addr (load_addr),
      .load_data (load_data),
      .note_sel  (note_sel),
      .note_on   (note_on),
      .busy      (busy),
      .done      (done),
      .step_idx  (step_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       on;
      logic [2:0] sel;
      logic       bsy;
      logic       dn;
      logic [4:0] idx;
   } obs_t;

   typedef struct {
      logic [31:0] ents;
      int          busy_cyc;
      int          on_cyc;
      logic [2:0]  fsel;
      logic [4:0]  fidx;
   } vec_t;

   logic [7:0] shadow [ML];
   logic [2:0] m_sel = '0;
   logic [4:0] m_idx = '0;
   obs_t       exp_q [$];
   vec_t       vecs [6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic obs_t now_obs();
      return {note_on, note_sel, busy, done, step_idx};
   endfunction

   task automatic write_entry(input int a, input logic [7:0] d);
      @(negedge clk);
      load_we   = 1'b1;
      load_addr = a[4:0];
      load_data = d;
      @(negedge clk);
      load_we = 1'b0;
      shadow[a] = d;
   endtask

   // Expected per-cycle outputs from start: each entry costs one fetch cycle plus
   // (dur+1)*TC play cycles; the end costs a fetch and a done cycle. Two passes when looping.
   task automatic build_exp();
      int         idx = 0;
      int         ends = 0;
      bit         fin = 1'b0;
      logic [2:0] sel = m_sel;
      logic [4:0] si = m_idx;
      logic [7:0] e;
      exp_q.delete();
      while (!fin) begin
         exp_q.push_back({1'b0, sel, 1'b1, 1'b0, si});
         if (idx >= ML || shadow[idx] == 8'hF0) begin
            exp_q.push_back({1'b0, sel, 1'b1, 1'b1, si});
            ends++;
            if (LOOP && idx != 0 && ends < 2) idx = 0;
            else fin = 1'b1;
         end else begin
            e  = shadow[idx];
            si = idx[4:0];
            if (!e[7]) sel = e[6:4];
            repeat ((int'(e[3:0]) + 1) * TC) exp_q.push_back({~e[7], sel, 1'b1, 1'b0, si});
            idx++;
         end
      end
   endtask

   task automatic run_check(input string name);
      obs_t e;
      build_exp();
      e = exp_q[0];
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         e = exp_q[k];
         check($sformatf("%s_cyc%0d", name, k), 32'(now_obs()), 32'(e));
         if (k == exp_q.size() - 1) begin
            stop  = 1'b1;
            start = 1'b0;
         end else begin
            start = ($urandom_range(0, 7) == 0);
         end
         @(negedge clk);
      end
      stop  = 1'b0;
      start = 1'b0;
      check($sformatf("%s_idle", name), 32'(now_obs()), 32'(obs_t'({1'b0, e.sel, 1'b0, 1'b0, e.idx})));
      m_sel = e.sel;
      m_idx = e.idx;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         nb;
      int         non;
      bit         seen;
      int         len;
      logic [7:0] d;
      logic [2:0] dsel;

      vecs[0] = '{32'hF0F0_3102, 24, 20, 3'd3, 5'd1};
      vecs[1] = '{32'hF0F0_F083, 19,  0, 3'd3, 5'd0};
      vecs[2] = '{32'hF0F0_F070,  7,  4, 3'd7, 5'd0};
      vecs[3] = '{32'hF0F0_F0F0,  2,  0, 3'd7, 5'd0};
      vecs[4] = '{32'hF0F0_F00F, 67, 64, 3'd0, 5'd0};
      vecs[5] = '{32'hF022_8351, 41, 20, 3'd2, 5'd2};
      for (int i = 0; i < ML; i++) shadow[i] = 8'h00;

      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(now_obs()), 32'h0);
      resetn = 1'b1;

      for (int v = 0; v < 6; v++) begin
         for (int j = 0; j < 4; j++) write_entry(j, vecs[v].ents[8*j +: 8]);
         nb = 0; non = 0; seen = 1'b0; dsel = '0;
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int c = 0; c < 500 && !seen; c++) begin
            if (busy) nb++;
            if (note_on) non++;
            if (done) begin
               seen = 1'b1;
               dsel = note_sel;
               check($sformatf("vec%0d_step_idx", v), 32'(step_idx), 32'(vecs[v].fidx));
               stop = 1'b1;
            end
            @(negedge clk);
         end
         stop = 1'b0;
         check($sformatf("vec%0d_done_seen", v), 32'(seen), 32'd1);
         check($sformatf("vec%0d_busy_cycles", v), 32'(nb), 32'(vecs[v].busy_cyc));
         check($sformatf("vec%0d_on_cycles", v), 32'(non), 32'(vecs[v].on_cyc));
         check($sformatf("vec%0d_note_sel", v), 32'(dsel), 32'(vecs[v].fsel));
         check($sformatf("vec%0d_idle_after", v), 32'(busy), 32'd0);
         m_sel = vecs[v].fsel;
         m_idx = vecs[v].fidx;
      end

      write_entry(0, 8'h02);
      write_entry(1, 8'h31);
      write_entry(2, 8'hF0);
      run_check("plan_basic");
      write_entry(0, 8'h41);
      write_entry(1, 8'h83);
      write_entry(2, 8'h12);
      write_entry(3, 8'hF0);
      run_check("rest_between");
      write_entry(0, 8'hF0);
      run_check("empty");

      write_entry(0, 8'h0F);
      write_entry(1, 8'hF0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_note_on", 32'(note_on), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (80) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      check("stop_no_done", 32'(seen), 32'd0);
      m_sel = 3'd0;
      m_idx = 5'd0;

      write_entry(0, 8'h13);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      load_we = 1'b1; load_addr = 5'd0; load_data = 8'h55; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      load_we = 1'b0; start = 1'b0; stop = 1'b0;
      check("startstop_busy", 32'(busy), 32'd0);
      check("startstop_note_on", 32'(note_on), 32'd0);
      m_sel = 3'd1;
      m_idx = 5'd0;
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check("idle_startstop_busy", 32'(busy), 32'd0);
      run_check("table_unchanged");

      for (int i = 0; i < ML; i++) begin
         d = {1'($urandom), 3'($urandom), 3'b000, 1'($urandom)};
         if (d == 8'hF0) d = 8'hF1;
         write_entry(i, d);
      end
      run_check("full_table");

      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(0, 5);
         for (int i = 0; i < len; i++) begin
            d = {1'($urandom), 3'($urandom), 2'b00, 2'($urandom_range(0, 2))};
            if (d == 8'hF0) d = 8'h70;
            write_entry(i, d);
         end
         write_entry(len, 8'hF0);
         run_check($sformatf("rand%0d", r));
      end

      write_entry(0, 8'h52);
      write_entry(1, 8'hF0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("async_reset_note_on", 32'(note_on), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < ML; i++) shadow[i] = 8'h00;
      m_sel = 3'd0;
      m_idx = 5'd0;
      run_check("cleared_table");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
